// File: rtl/microcode_sequencer.sv
// microcode_sequencer
//   Fetch/execute sequencer for the SAP-2 core. Owns PC, IR and operand latches,
//   fetches variable-length instructions (opcode + 0..MAX_OPERAND_BYTES operands)
//   from a synchronous RAM, then steps a microstep counter that addresses an
//   external microcode ROM ({opcode, microstep}). Conditional PC loads are
//   resolved against the ALU flags.
//
//   Optional build macro: SEQ_SINGLE_STEP_EN adds input step_req; in execute a
//   microstep commits only in cycles where step_req=1.
//
// Ports
//   clk, reset          clock (rising edge), async active-high reset
//   mem_addr, mem_rd    fetch address (= pc) and read strobe (data next cycle)
//   mem_rdata           RAM read data
//   operand_bytes       operand count decoded from the current opcode
//   uc_last_step/uc_halt/uc_load_pc/uc_check  microcode control inputs
//   flag_z/flag_c/flag_n ALU flags
//   opcode, operands    IR and operand latches (operand[0] in LSBs)
//   microstep           current execute step
//   exec_strobe         a microstep commits this cycle
//   pc, state, halted   program counter, FSM encoding, halt indicator
//   ustep_overflow      sticky: step limit reached without uc_last_step
module microcode_sequencer #(
  parameter int unsigned DATA_WIDTH        = 8,
  parameter int unsigned ADDR_WIDTH        = 16,
  parameter int unsigned MAX_OPERAND_BYTES = 2,
  parameter int unsigned MAX_MICROSTEPS    = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = 16'hF000,
  localparam int unsigned MS_W = $clog2(MAX_MICROSTEPS),
  localparam int unsigned OB_W = $clog2(MAX_OPERAND_BYTES + 1)
) (
  input  logic                                  clk,
  input  logic                                  reset,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic                                  step_req,
`endif
  output logic [ADDR_WIDTH-1:0]                 mem_addr,
  output logic                                  mem_rd,
  input  logic [DATA_WIDTH-1:0]                 mem_rdata,
  input  logic [OB_W-1:0]                       operand_bytes,
  input  logic                                  uc_last_step,
  input  logic                                  uc_halt,
  input  logic                                  uc_load_pc,
  input  logic [3:0]                            uc_check,
  input  logic                                  flag_z,
  input  logic                                  flag_c,
  input  logic                                  flag_n,
  output logic [DATA_WIDTH-1:0]                 opcode,
  output logic [MAX_OPERAND_BYTES*DATA_WIDTH-1:0] operands,
  output logic [MS_W-1:0]                       microstep,
  output logic                                  exec_strobe,
  output logic [ADDR_WIDTH-1:0]                 pc,
  output logic [2:0]                            state,
  output logic                                  halted,
  output logic                                  ustep_overflow
);

  typedef enum logic [2:0] {
    S_RESET          = 3'd0,
    S_INIT           = 3'd1,
    S_LATCH_ADDR     = 3'd2,
    S_READ_BYTE      = 3'd3,
    S_LATCH_BYTE     = 3'd4,
    S_CHK_MORE_BYTES = 3'd5,
    S_EXECUTE        = 3'd6,
    S_HALT           = 3'd7
  } fsm_state_t;

  localparam int unsigned          TW      = 2 * DATA_WIDTH;
  localparam logic [MS_W-1:0]      MS_LAST = MS_W'(MAX_MICROSTEPS - 1);
  localparam logic [OB_W-1:0]      OB_MAX  = OB_W'(MAX_OPERAND_BYTES);

  fsm_state_t            state_q;
  logic [OB_W-1:0]       byte_idx;
  logic [OB_W-1:0]       n_ops;
  logic                  step_ok;
  logic                  cond_ok;
  logic [TW-1:0]         tgt_bytes;
  logic [ADDR_WIDTH-1:0] target;

`ifdef SEQ_SINGLE_STEP_EN
  assign step_ok = step_req;
`else
  assign step_ok = 1'b1;
`endif

  assign state       = state_q;
  assign mem_addr    = pc;
  assign halted      = (state_q == S_HALT);
  assign exec_strobe = (state_q == S_EXECUTE) && step_ok;

  assign n_ops = (operand_bytes > OB_MAX) ? OB_MAX : operand_bytes;

  // uc_check = {negative, carry, not_zero, zero}; all-zero means unconditional
  assign cond_ok = !(uc_check[0] && !flag_z) && !(uc_check[1] && flag_z) &&
                   !(uc_check[2] && !flag_c) && !(uc_check[3] && !flag_n);

  // Jump target is {operand[1], operand[0]}, fitted to the PC width
  generate
    if (MAX_OPERAND_BYTES >= 2) begin : g_tgt_two
      assign tgt_bytes = operands[TW-1:0];
    end else begin : g_tgt_one
      assign tgt_bytes = {{DATA_WIDTH{1'b0}}, operands[DATA_WIDTH-1:0]};
    end
    if (ADDR_WIDTH <= TW) begin : g_tgt_trunc
      assign target = tgt_bytes[ADDR_WIDTH-1:0];
    end else begin : g_tgt_ext
      assign target = {{(ADDR_WIDTH-TW){1'b0}}, tgt_bytes};
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_RESET;
      pc             <= '0;
      opcode         <= '0;
      operands       <= '0;
      microstep      <= '0;
      byte_idx       <= '0;
      mem_rd         <= 1'b0;
      ustep_overflow <= 1'b0;
    end else begin
      mem_rd <= 1'b0;
      case (state_q)
        S_RESET: state_q <= S_INIT;
        S_INIT: begin
          pc      <= RESET_VECTOR;
          state_q <= S_LATCH_ADDR;
        end
        S_LATCH_ADDR: begin
          mem_rd  <= 1'b1;
          state_q <= S_READ_BYTE;
        end
        S_READ_BYTE: state_q <= S_LATCH_BYTE;
        S_LATCH_BYTE: begin
          if (byte_idx == '0) begin
            opcode <= mem_rdata;
          end
          for (int unsigned i = 0; i < MAX_OPERAND_BYTES; i++) begin
            if (byte_idx == OB_W'(i + 1)) begin
              operands[i*DATA_WIDTH +: DATA_WIDTH] <= mem_rdata;
            end
          end
          pc      <= pc + ADDR_WIDTH'(1);
          state_q <= S_CHK_MORE_BYTES;
        end
        S_CHK_MORE_BYTES: begin
          if (byte_idx < n_ops) begin
            byte_idx <= byte_idx + OB_W'(1);
            state_q  <= S_LATCH_ADDR;
          end else begin
            byte_idx  <= '0;
            microstep <= '0;
            state_q   <= S_EXECUTE;
          end
        end
        S_EXECUTE: begin
          if (step_ok) begin
            if (uc_halt) begin
              state_q <= S_HALT;
            end else begin
              if (uc_load_pc && cond_ok) begin
                pc <= target;
              end
              if (uc_last_step || (microstep == MS_LAST)) begin
                if (!uc_last_step) begin
                  ustep_overflow <= 1'b1;
                end
                microstep <= '0;
                state_q   <= S_LATCH_ADDR;
              end else begin
                microstep <= microstep + MS_W'(1);
              end
            end
          end
        end
        S_HALT: state_q <= S_HALT;
        default: state_q <= S_RESET;
      endcase
    end
  end

endmodule
